// File: rtl/loop_sequencer_pkg.sv
// Shared state encoding and fixed-point constants for the V-I loop sequencer.
package loop_sequencer_pkg;

  localparam int unsigned Q15_W           = 16;
  localparam int unsigned ADC_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_SAMPLE    = 3'd2,
    ST_COMPUTE   = 3'd3,
    ST_COMMIT    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/loop_sequencer_vref_ramp.sv
// Slew limiter stepping the voltage reference toward its target without overshoot or wrap.
module loop_sequencer_vref_ramp
  import loop_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic signed [Q15_W-1:0] target_i,
  input  logic        [Q15_W-1:0] step_i,
  output logic signed [Q15_W-1:0] ramp_o
);

  logic signed [Q15_W-1:0] ramp_q, ramp_d, ramp_next;
  logic signed [Q15_W:0]   diff;
  logic        [Q15_W:0]   mag;

  // Difference is taken one bit wider so full-scale swings cannot wrap.
  always_comb begin
    diff = {target_i[Q15_W-1], target_i} - {ramp_q[Q15_W-1], ramp_q};
    mag  = diff[Q15_W] ? $unsigned(-diff) : $unsigned(diff);
    if ((step_i == '0) || (mag <= {1'b0, step_i})) begin
      ramp_next = target_i;
    end else if (diff[Q15_W]) begin
      ramp_next = ramp_q - step_i;
    end else begin
      ramp_next = ramp_q + step_i;
    end
    ramp_d = ramp_q;
    if (clear_i) begin
      ramp_d = '0;
    end else if (load_i) begin
      ramp_d = ramp_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  assign ramp_o = ramp_q;

endmodule

// File: rtl/loop_sequencer.sv
// Per-sample scheduler: loop tick, ADC handshake, PID step and PWM-aligned duty commit.
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int unsigned PER_W       = 16,
  parameter int unsigned ADC_TIMEOUT = ADC_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    fault_in,
  input  logic        [PER_W-1:0] period,
  input  logic signed [Q15_W-1:0] vref_target,
  input  logic        [Q15_W-1:0] ramp_step,
  input  logic                    clear_err,
  output logic                    adc_req,
  input  logic                    adc_valid,
  input  logic signed [Q15_W-1:0] v_adc,
  input  logic signed [Q15_W-1:0] i_adc,
  output logic signed [Q15_W-1:0] v_s,
  output logic signed [Q15_W-1:0] i_s,
  output logic signed [Q15_W-1:0] vref_ramp,
  output logic                    pid_step,
  input  logic                    pid_done,
  input  logic signed [Q15_W-1:0] u_in,
  input  logic                    pwm_sync,
  output logic signed [Q15_W-1:0] duty_out,
  output logic                    duty_upd,
  output logic                    timeout_err,
  output logic        [7:0]       overrun_cnt,
  output logic        [2:0]       state
);

  localparam int unsigned TO_W = $clog2(ADC_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ADC_TIMEOUT - 1);

  seq_state_e              state_q, state_d;
  logic        [PER_W-1:0] cnt_q, cnt_d, reload;
  logic        [TO_W-1:0]  to_q, to_d;
  logic signed [Q15_W-1:0] v_q, v_d, i_q, i_d, pend_q, pend_d, duty_q, duty_d;
  logic                    step_q, step_d, upd_q, upd_d;
  logic                    to_err_q, to_err_d;
  logic        [7:0]       ovr_q, ovr_d;
  logic                    abort, tick, timeout_ev, overrun_ev, ramp_load, ramp_clear;

  assign abort  = !enable || fault_in;
  assign tick   = (state_q != ST_IDLE) && (cnt_q == '0);
  assign reload = (period < PER_W'(2)) ? PER_W'(1) : period - PER_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_d       = '0;
    v_d        = v_q;
    i_d        = i_q;
    pend_d     = pend_q;
    duty_d     = duty_q;
    step_d     = 1'b0;
    upd_d      = 1'b0;
    to_err_d   = to_err_q;
    ovr_d      = ovr_q;
    timeout_ev = 1'b0;
    overrun_ev = 1'b0;
    ramp_load  = 1'b0;
    ramp_clear = 1'b0;
    if (abort) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      v_d        = '0;
      i_d        = '0;
      pend_d     = '0;
      duty_d     = '0;
      ramp_clear = 1'b1;
    end else begin
      if (state_q != ST_IDLE) begin
        cnt_d = (cnt_q == '0) ? reload : cnt_q - PER_W'(1);
      end
      case (state_q)
        ST_IDLE:      state_d = ST_WAIT_TICK;
        ST_WAIT_TICK: if (tick) state_d = ST_SAMPLE;
        ST_SAMPLE: begin
          overrun_ev = tick;
          if (adc_valid) begin
            v_d     = v_adc;
            i_d     = i_adc;
            step_d  = 1'b1;
            state_d = ST_COMPUTE;
          end else if (to_q == TO_LAST) begin
            timeout_ev = 1'b1;
            state_d    = ST_WAIT_TICK;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        ST_COMPUTE: begin
          overrun_ev = tick;
          if (pid_done) begin
            pend_d  = u_in;
            state_d = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          overrun_ev = tick;
          if (pwm_sync) begin
            duty_d    = pend_q;
            upd_d     = 1'b1;
            ramp_load = 1'b1;
            state_d   = ST_WAIT_TICK;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Error events take priority over a simultaneous clear.
    if (clear_err) to_err_d = 1'b0;
    if (timeout_ev) to_err_d = 1'b1;
    if (overrun_ev) begin
      ovr_d = (ovr_q == 8'hFF) ? ovr_q : ovr_q + 8'd1;
    end else if (clear_err) begin
      ovr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      to_q     <= '0;
      v_q      <= '0;
      i_q      <= '0;
      pend_q   <= '0;
      duty_q   <= '0;
      step_q   <= 1'b0;
      upd_q    <= 1'b0;
      to_err_q <= 1'b0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      v_q      <= v_d;
      i_q      <= i_d;
      pend_q   <= pend_d;
      duty_q   <= duty_d;
      step_q   <= step_d;
      upd_q    <= upd_d;
      to_err_q <= to_err_d;
      ovr_q    <= ovr_d;
    end
  end

  loop_sequencer_vref_ramp u_ramp (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (ramp_clear),
    .load_i   (ramp_load),
    .target_i (vref_target),
    .step_i   (ramp_step),
    .ramp_o   (vref_ramp)
  );

  assign adc_req     = (state_q == ST_SAMPLE);
  assign v_s         = v_q;
  assign i_s         = i_q;
  assign pid_step    = step_q;
  assign duty_out    = duty_q;
  assign duty_upd    = upd_q;
  assign timeout_err = to_err_q;
  assign overrun_cnt = ovr_q;
  assign state       = state_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer with ADC, PID and PWM-sync responders.
module tb_loop_sequencer;

  logic               clk, rst, enable, fault_in, clear_err;
  logic        [15:0] period, ramp_step;
  logic signed [15:0] vref_target, v_adc, i_adc, u_in;
  logic               adc_req, adc_valid, pid_step, pid_done, pwm_sync, duty_upd, timeout_err;
  logic signed [15:0] v_s, i_s, vref_ramp, duty_out;
  logic        [7:0]  overrun_cnt;
  logic        [2:0]  state;

  logic adc_auto, pid_auto, pid_kick, sync_en, pid_done_auto;
  int   adc_lat, pid_lat;
  int   n_total = 0, n_bad = 0;

  loop_sequencer #(.PER_W(16), .ADC_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fault_in(fault_in), .period(period),
    .vref_target(vref_target), .ramp_step(ramp_step), .clear_err(clear_err),
    .adc_req(adc_req), .adc_valid(adc_valid), .v_adc(v_adc), .i_adc(i_adc),
    .v_s(v_s), .i_s(i_s), .vref_ramp(vref_ramp), .pid_step(pid_step),
    .pid_done(pid_done), .u_in(u_in), .pwm_sync(pwm_sync), .duty_out(duty_out),
    .duty_upd(duty_upd), .timeout_err(timeout_err), .overrun_cnt(overrun_cnt),
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign pid_done = pid_done_auto | pid_kick;

  // ADC frontend: valid in the adc_lat-th cycle of an asserted request.
  initial begin
    int age;
    age = 0;
    adc_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      age = adc_req ? age + 1 : 0;
      adc_valid = adc_auto && adc_req && (age == adc_lat);
    end
  end

  // PID core: done pid_lat cycles after the step strobe.
  initial begin
    int cd;
    cd = 0;
    pid_done_auto = 1'b0;
    forever begin
      @(posedge clk); #1;
      pid_done_auto = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) pid_done_auto = 1'b1;
      end
      if (pid_step && pid_auto) cd = pid_lat;
    end
  end

  // PWM counter wrap every 50 clocks.
  initial begin
    int ph;
    ph = 0;
    pwm_sync = 1'b0;
    forever begin
      @(posedge clk); #1;
      pwm_sync = sync_en && (ph == 0);
      ph = (ph == 49) ? 0 : ph + 1;
    end
  end

  int n_req = 0, n_step = 0, n_upd = 0, step_lat = -1;
  logic signed [15:0] upd_vref[$];
  logic signed [15:0] upd_duty[$];

  initial begin
    int   cyc, valid_cyc;
    logic req_prev;
    cyc = 0; valid_cyc = -100; req_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (adc_req && !req_prev) n_req++;
      req_prev = adc_req;
      if (adc_valid) valid_cyc = cyc;
      if (pid_step) begin
        n_step++;
        step_lat = cyc - valid_cyc;
      end
      if (duty_upd) begin
        n_upd++;
        upd_vref.push_back(vref_ramp);
        upd_duty.push_back(duty_out);
      end
    end
  end

  task automatic check_eq(input string tag, input logic signed [31:0] act,
                          input logic signed [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic signed [15:0] vref_at(input int idx);
    if (idx < upd_vref.size()) return upd_vref[idx];
    return 'x;
  endfunction

  function automatic logic signed [15:0] duty_at(input int idx);
    if (idx < upd_duty.size()) return upd_duty[idx];
    return 'x;
  endfunction

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic restart();
    enable = 1'b0;
    step_clk(2);
    clear_err = 1'b1;
    step_clk(1);
    clear_err = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max);
    int n;
    n = 0;
    while (state !== s && n < max) begin
      step_clk(1);
      n++;
    end
    check_eq(tag, 32'(state), 32'(s));
  endtask

  task automatic run_ramp(input logic signed [15:0] tgt, input logic [15:0] stp,
                          input logic signed [15:0] u, input int cycles, output int base);
    restart();
    period = 16'd100; vref_target = tgt; ramp_step = stp; u_in = u;
    adc_auto = 1'b1; adc_lat = 5; pid_auto = 1'b1; pid_lat = 4; sync_en = 1'b1;
    base = upd_vref.size();
    enable = 1'b1;
    step_clk(cycles);
  endtask

  initial begin
    int b, r0, s0, o0, n;
    rst = 1'b1; enable = 1'b0; fault_in = 1'b0; clear_err = 1'b0; period = 16'd100;
    vref_target = '0; ramp_step = '0; v_adc = 16'sh1111; i_adc = -16'sh2222; u_in = '0;
    adc_auto = 1'b0; pid_auto = 1'b0; pid_kick = 1'b0; sync_en = 1'b1;
    adc_lat = 5; pid_lat = 4;
    step_clk(3);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_req", 32'(adc_req), 0);
    check_eq("rst_duty", 32'(duty_out), 0);
    check_eq("rst_vref", 32'(vref_ramp), 0);
    check_eq("rst_ovr", 32'(overrun_cnt), 0);
    check_eq("rst_tmo", 32'(timeout_err), 0);
    rst = 1'b0;
    step_clk(2);
    check_eq("idle_hold", 32'(state), 0);

    // Nominal loop with 0x1000 ramp toward 0x4000
    r0 = n_req; s0 = n_step; o0 = n_upd;
    run_ramp(16'sh4000, 16'h1000, 16'sh1234, 1000, b);
    check_eq("nom_req", n_req - r0, 10);
    check_eq("nom_step", n_step - s0, 10);
    check_eq("nom_upd", n_upd - o0, 10);
    check_eq("nom_step_lat", step_lat, 1);
    check_eq("nom_v_s", 32'(v_s), 'h1111);
    check_eq("nom_i_s", 32'(i_s), -'h2222);
    check_eq("ramp_up0", 32'(vref_at(b)), 'h1000);
    check_eq("ramp_up1", 32'(vref_at(b + 1)), 'h2000);
    check_eq("ramp_up2", 32'(vref_at(b + 2)), 'h3000);
    check_eq("ramp_up3", 32'(vref_at(b + 3)), 'h4000);
    check_eq("ramp_up4", 32'(vref_at(b + 4)), 'h4000);
    check_eq("nom_duty0", 32'(duty_at(b)), 'h1234);
    check_eq("nom_duty9", 32'(duty_at(b + 9)), 'h1234);
    check_eq("nom_ovr", 32'(overrun_cnt), 0);
    check_eq("nom_tmo", 32'(timeout_err), 0);

    o0 = n_upd;
    run_ramp(16'sh0800, 16'h1000, 16'sh0555, 300, b);
    check_eq("land_upd", n_upd - o0, 3);
    check_eq("land0", 32'(vref_at(b)), 'h0800);
    check_eq("land2", 32'(vref_at(b + 2)), 'h0800);

    o0 = n_upd;
    run_ramp(-16'sh4000, 16'h1000, -16'sh0100, 500, b);
    check_eq("neg_upd", n_upd - o0, 5);
    check_eq("ramp_dn0", 32'(vref_at(b)), -'h1000);
    check_eq("ramp_dn1", 32'(vref_at(b + 1)), -'h2000);
    check_eq("ramp_dn2", 32'(vref_at(b + 2)), -'h3000);
    check_eq("ramp_dn3", 32'(vref_at(b + 3)), -'h4000);
    check_eq("ramp_dn4", 32'(vref_at(b + 4)), -'h4000);
    check_eq("neg_duty", 32'(duty_at(b)), -'h0100);

    run_ramp(16'sh7FFF, 16'h0000, 16'sh0001, 100, b);
    check_eq("jump", 32'(vref_at(b)), 'h7FFF);

    // Fault pulse during COMPUTE
    restart();
    vref_target = 16'sh4000; ramp_step = 16'h1000; u_in = 16'sh0321;
    pid_auto = 1'b1; adc_auto = 1'b1;
    o0 = n_upd;
    enable = 1'b1;
    n = 0;
    while (n_upd == o0 && n < 200) begin
      step_clk(1);
      n++;
    end
    check_eq("abt_pre_vref", 32'(vref_ramp), 'h1000);
    check_eq("abt_pre_duty", 32'(duty_out), 'h0321);
    pid_auto = 1'b0;
    wait_state("abt_reach_compute", 3'd3, 200);
    fault_in = 1'b1;
    step_clk(1);
    check_eq("abt_state", 32'(state), 0);
    check_eq("abt_duty", 32'(duty_out), 0);
    check_eq("abt_vref", 32'(vref_ramp), 0);
    check_eq("abt_req", 32'(adc_req), 0);
    fault_in = 1'b0; pid_kick = 1'b1;
    step_clk(1);
    pid_kick = 1'b0;
    check_eq("abt_restart", 32'(state), 1);
    check_eq("abt_late_done", 32'(duty_out), 0);
    check_eq("abt_no_upd", n_upd - o0, 1);
    step_clk(1);
    check_eq("abt_retick", 32'(state), 2);
    pid_auto = 1'b1;

    // ADC timeout
    restart();
    period = 16'd100; adc_auto = 1'b0;
    s0 = n_step;
    enable = 1'b1;
    n = 0;
    while (!adc_req && n < 10) begin
      step_clk(1);
      n++;
    end
    n = 0;
    while (adc_req && n < 200) begin
      step_clk(1);
      n++;
    end
    check_eq("tmo_req_len", n, 64);
    check_eq("tmo_flag", 32'(timeout_err), 1);
    check_eq("tmo_state", 32'(state), 1);
    n = 0;
    while (!adc_req && n < 200) begin
      step_clk(1);
      n++;
    end
    check_eq("tmo_retry_gap", n, 36);
    check_eq("tmo_no_step", n_step - s0, 0);
    check_eq("tmo_ovr", 32'(overrun_cnt), 0);
    clear_err = 1'b1;
    step_clk(1);
    clear_err = 1'b0;
    check_eq("tmo_clear", 32'(timeout_err), 0);

    // Period clamp: every tick while stuck in SAMPLE counts as an overrun
    restart();
    period = 16'd0; adc_auto = 1'b0;
    enable = 1'b1;
    n = 0;
    while (!adc_req && n < 10) begin
      step_clk(1);
      n++;
    end
    step_clk(4);
    o0 = int'(overrun_cnt);
    step_clk(20);
    check_eq("clamp_p0", int'(overrun_cnt) - o0, 10);
    period = 16'd1;
    o0 = int'(overrun_cnt);
    step_clk(20);
    check_eq("clamp_p1", int'(overrun_cnt) - o0, 10);

    // Overrun with late PID and saturation under a stalled commit
    restart();
    period = 16'd10; adc_auto = 1'b1; adc_lat = 5; pid_auto = 1'b1; pid_lat = 30;
    sync_en = 1'b0;
    enable = 1'b1;
    wait_state("ovr_reach_commit", 3'd4, 100);
    check_eq("ovr_late", 32'(overrun_cnt), 3);
    step_clk(10);
    check_eq("ovr_next", 32'(overrun_cnt), 4);
    step_clk(2600);
    check_eq("ovr_sat", 32'(overrun_cnt), 255);
    step_clk(30);
    check_eq("ovr_sat_hold", 32'(overrun_cnt), 255);
    enable = 1'b0;
    step_clk(1);
    clear_err = 1'b1;
    step_clk(1);
    clear_err = 1'b0;
    check_eq("ovr_clear", 32'(overrun_cnt), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
